// File: rtl/mod_buf_reader_if.sv
// Reader-side bundle: block-done handshake from the writer, buffer read port,
// and the ready/valid symbol output stream.
interface mod_buf_reader_if #(
  parameter int unsigned LUT_WIDTH  = 18,
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                         Done_In;
  logic [ADDR_WIDTH-1:0]        Last_addr_In;
  logic                         Wr_bank;
  logic                         Rd_bank;
  logic                         Rd_en;
  logic [ADDR_WIDTH-1:0]        Rd_addr;
  logic signed [LUT_WIDTH-1:0]  Rd_data_I;
  logic signed [LUT_WIDTH-1:0]  Rd_data_Q;
  logic signed [LUT_WIDTH-1:0]  Out_I;
  logic signed [LUT_WIDTH-1:0]  Out_Q;
  logic                         Out_Valid;
  logic                         Out_Ready;
  logic                         Out_Last;
  logic                         Busy;
  logic                         Overrun;

  // Environment side: writer, buffer memory and downstream sink
  modport master (
    output Done_In, Last_addr_In, Rd_data_I, Rd_data_Q, Out_Ready,
    input  Wr_bank, Rd_bank, Rd_en, Rd_addr, Out_I, Out_Q, Out_Valid,
    input  Out_Last, Busy, Overrun
  );

  // Reader side
  modport slave (
    input  Done_In, Last_addr_In, Rd_data_I, Rd_data_Q, Out_Ready,
    output Wr_bank, Rd_bank, Rd_en, Rd_addr, Out_I, Out_Q, Out_Valid,
    output Out_Last, Busy, Overrun
  );
endinterface

// File: rtl/mod_buf_reader.sv
// Ping-pong buffer reader: streams each closed block out of the read bank in
// address order through a 2-entry output FIFO, with one pending block slot.
module mod_buf_reader #(
  parameter int unsigned LUT_WIDTH  = 18,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MAX_SYM    = 1200
) (
  input logic             CLK_Mod,
  input logic             RST_Mod,
  mod_buf_reader_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0]       length_q, length_d;
  logic [ADDR_WIDTH-1:0]       rd_addr_q, rd_addr_d;
  logic                        issued_all_q, issued_all_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0]       pend_len_q, pend_len_d;
  logic                        overrun_q, overrun_d;

  logic                        rd_vld_q, rd_last_q;
  logic                        out_vld_q, out_last_q;
  logic signed [LUT_WIDTH-1:0] out_i_q, out_q_q;
  logic                        skid_vld_q, skid_last_q;
  logic signed [LUT_WIDTH-1:0] skid_i_q, skid_q_q;

  logic                        n_ok, pop, last_xfer, at_last, rd_en_c, start;
  logic [ADDR_WIDTH-1:0]       n_len, start_len;
  logic [1:0]                  occ_after;

  // A zero-length block is never a real block; oversize blocks are clamped
  assign n_ok  = bus.Done_In && (bus.Last_addr_In != '0);
  assign n_len = (bus.Last_addr_In > ADDR_WIDTH'(MAX_SYM)) ? ADDR_WIDTH'(MAX_SYM)
                                                            : bus.Last_addr_In;

  assign pop       = out_vld_q && bus.Out_Ready;
  assign last_xfer = pop && out_last_q;
  assign at_last   = (rd_addr_q == length_q - ADDR_WIDTH'(1));

  // Credit: FIFO entries left after this cycle's pop, plus the read landing now
  assign occ_after = 2'(out_vld_q) + 2'(skid_vld_q) - 2'(pop) + 2'(rd_vld_q);
  assign rd_en_c   = (state_q == READ) && !issued_all_q && (occ_after < 2'd2);

  // Control state register
  always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
    if (!RST_Mod) begin
      state_q      <= IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      length_q     <= '0;
      rd_addr_q    <= '0;
      issued_all_q <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_len_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      length_q     <= length_d;
      rd_addr_q    <= rd_addr_d;
      issued_all_q <= issued_all_d;
      pend_vld_q   <= pend_vld_d;
      pend_len_q   <= pend_len_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next state: block start, read address walk, pending slot and overrun
  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    length_d     = length_q;
    rd_addr_d    = rd_addr_q;
    issued_all_d = issued_all_q;
    pend_vld_d   = pend_vld_q;
    pend_len_d   = pend_len_q;
    overrun_d    = overrun_q;
    start        = 1'b0;
    start_len    = n_len;

    if (state_q == IDLE) begin
      start = n_ok;
    end else begin
      if (rd_en_c) begin
        if (at_last) issued_all_d = 1'b1;
        else         rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
      end
      if (last_xfer) begin
        if (pend_vld_q) begin
          start      = 1'b1;
          start_len  = pend_len_q;
          pend_vld_d = n_ok;
          pend_len_d = n_len;
        end else if (n_ok) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else if (n_ok) begin
        if (!pend_vld_q) begin
          pend_vld_d = 1'b1;
          pend_len_d = n_len;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (start) begin
      state_d      = READ;
      rd_bank_d    = wr_bank_q;
      wr_bank_d    = ~wr_bank_q;
      length_d     = start_len;
      rd_addr_d    = '0;
      issued_all_d = 1'b0;
    end
  end

  // Read tracking and 2-entry output FIFO (head = output registers, plus skid)
  always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
    if (!RST_Mod) begin
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_i_q    <= '0;
      skid_q_q    <= '0;
    end else begin
      rd_vld_q  <= rd_en_c;
      rd_last_q <= rd_en_c && at_last;
      if (pop) begin
        if (skid_vld_q) begin
          out_i_q    <= skid_i_q;
          out_q_q    <= skid_q_q;
          out_last_q <= skid_last_q;
          skid_vld_q <= rd_vld_q;
          if (rd_vld_q) begin
            skid_i_q    <= bus.Rd_data_I;
            skid_q_q    <= bus.Rd_data_Q;
            skid_last_q <= rd_last_q;
          end
        end else begin
          out_vld_q  <= rd_vld_q;
          out_last_q <= rd_vld_q && rd_last_q;
          if (rd_vld_q) begin
            out_i_q <= bus.Rd_data_I;
            out_q_q <= bus.Rd_data_Q;
          end
        end
      end else if (rd_vld_q) begin
        if (!out_vld_q) begin
          out_vld_q  <= 1'b1;
          out_i_q    <= bus.Rd_data_I;
          out_q_q    <= bus.Rd_data_Q;
          out_last_q <= rd_last_q;
        end else begin
          skid_vld_q  <= 1'b1;
          skid_i_q    <= bus.Rd_data_I;
          skid_q_q    <= bus.Rd_data_Q;
          skid_last_q <= rd_last_q;
        end
      end
    end
  end

  assign bus.Wr_bank   = wr_bank_q;
  assign bus.Rd_bank   = rd_bank_q;
  assign bus.Rd_en     = rd_en_c;
  assign bus.Rd_addr   = rd_addr_q;
  assign bus.Out_I     = out_i_q;
  assign bus.Out_Q     = out_q_q;
  assign bus.Out_Valid = out_vld_q;
  assign bus.Out_Last  = out_last_q;
  assign bus.Busy      = (state_q == READ);
  assign bus.Overrun   = overrun_q;

endmodule

// File: tb/tb_mod_buf_reader.sv
// Directed bench for mod_buf_reader with a synchronous two-bank buffer model.
module tb_mod_buf_reader;
  localparam int unsigned LW = 18;
  localparam int unsigned AW = 11;

  logic CLK_Mod = 1'b0;
  logic RST_Mod;
  always #5 CLK_Mod = ~CLK_Mod;

  mod_buf_reader_if #(.LUT_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  mod_buf_reader #(.LUT_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_SYM(1200)) dut (
    .CLK_Mod (CLK_Mod),
    .RST_Mod (RST_Mod),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Buffer contents are a closed-form function of bank and address
  function automatic logic [LW-1:0] ei(input int b, input int a);
    return LW'(b * 5000 + a + 7);
  endfunction
  function automatic logic [LW-1:0] eq(input int b, input int a);
    return LW'(-(b * 5000 + a + 7));
  endfunction

  logic [LW-1:0] mem_i, mem_q;
  always @(posedge CLK_Mod) begin
    if (bus.Rd_en) begin
      mem_i <= ei(int'(bus.Rd_bank), int'(bus.Rd_addr));
      mem_q <= eq(int'(bus.Rd_bank), int'(bus.Rd_addr));
    end
  end
  assign bus.Rd_data_I = mem_i;
  assign bus.Rd_data_Q = mem_q;

  // Logs of transfers and issued reads
  int            cyc;
  logic [LW-1:0] gi[$], gq[$];
  logic          gl[$];
  int            gc[$], ra[$], rc[$];
  logic          s_valid, s_last;
  logic [LW-1:0] s_i, s_q;
  bit            any_valid;

  task automatic clear_logs();
    gi.delete(); gq.delete(); gl.delete(); gc.delete(); ra.delete(); rc.delete();
    any_valid = 0;
  endtask

  // One clock: drive inputs at negedge, let them settle, sample outputs
  task automatic tick(input logic rdy, input logic done, input int n);
    @(negedge CLK_Mod);
    bus.Done_In      = done;
    bus.Last_addr_In = AW'(n);
    bus.Out_Ready    = rdy;
    #1;
    cyc++;
    s_valid = bus.Out_Valid;
    s_last  = bus.Out_Last;
    s_i     = bus.Out_I;
    s_q     = bus.Out_Q;
    if (bus.Out_Valid) any_valid = 1;
    if (bus.Out_Valid && rdy) begin
      gi.push_back(bus.Out_I); gq.push_back(bus.Out_Q);
      gl.push_back(bus.Out_Last); gc.push_back(cyc);
    end
    if (bus.Rd_en) begin
      ra.push_back(int'(bus.Rd_addr)); rc.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    RST_Mod = 1'b0;
    bus.Done_In = 1'b0; bus.Last_addr_In = '0; bus.Out_Ready = 1'b1;
    repeat (3) @(negedge CLK_Mod);
    #1;
    checks++; if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.Out_Valid); end
    checks++; if (bus.Busy !== 1'b0 || bus.Rd_en !== 1'b0) begin errors++; $display("FAIL reset_busy_rden got %b%b exp 00", bus.Busy, bus.Rd_en); end
    checks++; if (bus.Wr_bank !== 1'b0 || bus.Rd_bank !== 1'b0) begin errors++; $display("FAIL reset_banks got %b%b exp 00", bus.Wr_bank, bus.Rd_bank); end
    checks++; if (bus.Out_I !== '0 || bus.Out_Q !== '0 || bus.Out_Last !== 1'b0 || bus.Rd_addr !== '0 || bus.Overrun !== 1'b0) begin
      errors++; $display("FAIL reset_regs got I=%h Q=%h L=%b A=%0d O=%b exp zeros", bus.Out_I, bus.Out_Q, bus.Out_Last, bus.Rd_addr, bus.Overrun);
    end
    RST_Mod = 1'b1;
    repeat (2) tick(1, 0, 0);
  endtask

  task automatic test_basic();
    int d;
    clear_logs();
    tick(1, 1, 4); d = cyc;
    tick(1, 0, 0);
    checks++; if (bus.Wr_bank !== 1'b1 || bus.Rd_bank !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++; $display("FAIL basic_start got wr=%b rd=%b busy=%b exp 1 0 1", bus.Wr_bank, bus.Rd_bank, bus.Busy);
    end
    repeat (8) tick(1, 0, 0);
    checks++; if (ra.size() != 4 || ra[0] != 0 || ra[3] != 3 || rc[0] != d + 1 || rc[3] != d + 4) begin
      errors++; $display("FAIL basic_rdaddr got n=%0d exp 4 reads at addr 0..3 cycles %0d..%0d", ra.size(), d + 1, d + 4);
    end
    checks++; if (gi.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", gi.size()); end
    for (int i = 0; i < gi.size() && i < 4; i++) begin
      checks++; if (gi[i] !== ei(0, i) || gq[i] !== eq(0, i) || gl[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_sym%0d got I=%h Q=%h L=%b exp I=%h Q=%h L=%b", i, gi[i], gq[i], gl[i], ei(0, i), eq(0, i), i == 3);
      end
    end
    checks++; if (gc.size() > 0 && gc[0] != d + 3) begin errors++; $display("FAIL basic_latency got cycle %0d exp %0d", gc[0], d + 3); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", bus.Busy); end
  endtask

  task automatic test_backpressure();
    logic          p_stall, p_last;
    logic [LW-1:0] p_i, p_q;
    int            bad;
    clear_logs();
    bad = 0;
    tick(1, 1, 6);
    for (int i = 0; i < 30; i++) begin
      p_stall = s_valid && !bus.Out_Ready;
      p_i = s_i; p_q = s_q; p_last = s_last;
      tick(logic'(i % 2), 0, 0);
      if (p_stall && (s_valid !== 1'b1 || s_i !== p_i || s_q !== p_q || s_last !== p_last)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls exp 0", bad); end
    checks++; if (gi.size() != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", gi.size()); end
    bad = 0;
    for (int i = 0; i < gi.size() && i < 6; i++)
      if (gi[i] !== ei(1, i) || gq[i] !== eq(1, i) || gl[i] !== (i == 5)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d wrong symbols exp 0", bad); end
  endtask

  task automatic test_pending();
    int bad;
    clear_logs();
    tick(1, 1, 5);
    tick(1, 0, 0);
    tick(1, 1, 3);
    repeat (20) tick(1, 0, 0);
    checks++; if (gi.size() != 8) begin errors++; $display("FAIL pend_count got %0d exp 8", gi.size()); end
    bad = 0;
    for (int i = 0; i < gi.size() && i < 8; i++) begin
      if (i < 5) begin
        if (gi[i] !== ei(0, i) || gq[i] !== eq(0, i) || gl[i] !== (i == 4)) bad++;
      end else begin
        if (gi[i] !== ei(1, i - 5) || gq[i] !== eq(1, i - 5) || gl[i] !== (i == 7)) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pend_order got %0d wrong symbols exp 0", bad); end
    checks++; if (bus.Wr_bank !== 1'b0 || bus.Rd_bank !== 1'b1 || bus.Overrun !== 1'b0) begin
      errors++; $display("FAIL pend_banks got wr=%b rd=%b ovr=%b exp 0 1 0", bus.Wr_bank, bus.Rd_bank, bus.Overrun);
    end
  endtask

  task automatic test_overrun();
    int bad;
    clear_logs();
    tick(1, 1, 4);
    tick(1, 1, 2);
    tick(1, 1, 2);
    tick(1, 0, 0);
    checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", bus.Overrun); end
    repeat (20) tick(1, 0, 0);
    checks++; if (gi.size() != 6) begin errors++; $display("FAIL ovr_count got %0d exp 6", gi.size()); end
    bad = 0;
    for (int i = 0; i < gi.size() && i < 6; i++) begin
      if (i < 4) begin
        if (gi[i] !== ei(0, i) || gl[i] !== (i == 3)) bad++;
      end else begin
        if (gi[i] !== ei(1, i - 4) || gl[i] !== (i == 5)) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovr_order got %0d wrong symbols exp 0", bad); end
    checks++; if (bus.Overrun !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL ovr_sticky got ovr=%b busy=%b exp 1 0", bus.Overrun, bus.Busy);
    end
  endtask

  task automatic test_bounds();
    int bad, nlast;
    clear_logs();
    tick(1, 1, 0);
    repeat (5) tick(1, 0, 0);
    checks++; if (bus.Busy !== 1'b0 || bus.Wr_bank !== 1'b0 || any_valid || ra.size() != 0) begin
      errors++; $display("FAIL zero_ignored got busy=%b wr=%b valid=%0d reads=%0d exp 0 0 0 0", bus.Busy, bus.Wr_bank, any_valid, ra.size());
    end
    clear_logs();
    tick(1, 1, 1500);
    repeat (1215) tick(1, 0, 0);
    checks++; if (gi.size() != 1200) begin errors++; $display("FAIL clamp_count got %0d exp 1200", gi.size()); end
    bad = 0; nlast = 0;
    for (int i = 0; i < gi.size(); i++) begin
      if (gi[i] !== ei(0, i) || gq[i] !== eq(0, i)) bad++;
      if (gl[i]) nlast++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clamp_data got %0d wrong symbols exp 0", bad); end
    checks++; if (nlast != 1 || gl.size() != 1200 || gl[1199] !== 1'b1) begin
      errors++; $display("FAIL clamp_last got %0d last flags exp one at index 1199", nlast);
    end
    checks++; if (ra.size() != 1200 || ra[1199] != 1199 || bus.Overrun !== 1'b1) begin
      errors++; $display("FAIL clamp_reads got %0d reads ovr=%b exp 1200 ending at 1199, ovr unchanged 1", ra.size(), bus.Overrun);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    tick(1, 1, 10);
    n = 0;
    while (gi.size() < 2 && n < 50) begin tick(1, 0, 0); n++; end
    checks++; if (gi.size() != 2) begin errors++; $display("FAIL mid_reach got %0d symbols exp 2", gi.size()); end
    @(negedge CLK_Mod);
    RST_Mod = 1'b0;
    #1;
    checks++; if (bus.Out_Valid !== 1'b0 || bus.Out_Last !== 1'b0 || bus.Out_I !== '0 || bus.Out_Q !== '0) begin
      errors++; $display("FAIL mid_out got V=%b L=%b I=%h Q=%h exp zeros", bus.Out_Valid, bus.Out_Last, bus.Out_I, bus.Out_Q);
    end
    checks++; if (bus.Busy !== 1'b0 || bus.Rd_en !== 1'b0 || bus.Rd_addr !== '0 || bus.Wr_bank !== 1'b0 || bus.Rd_bank !== 1'b0 || bus.Overrun !== 1'b0) begin
      errors++; $display("FAIL mid_ctrl got busy=%b en=%b addr=%0d wr=%b rd=%b ovr=%b exp zeros",
                         bus.Busy, bus.Rd_en, bus.Rd_addr, bus.Wr_bank, bus.Rd_bank, bus.Overrun);
    end
    @(negedge CLK_Mod);
    RST_Mod = 1'b1;
    clear_logs();
    repeat (15) tick(1, 0, 0);
    checks++; if (any_valid || ra.size() != 0) begin errors++; $display("FAIL mid_quiet got valid=%0d reads=%0d exp 0 0", any_valid, ra.size()); end
    tick(1, 1, 1);
    repeat (6) tick(1, 0, 0);
    checks++; if (gi.size() != 1 || gi[0] !== ei(0, 0) || gl[0] !== 1'b1 || bus.Wr_bank !== 1'b1) begin
      errors++; $display("FAIL mid_restart got n=%0d wr=%b exp one last symbol from bank 0, wr=1", gi.size(), bus.Wr_bank);
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_pending();
    test_overrun();
    test_bounds();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
